// File: rtl/ahb_sub_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ahb_sub_pkg
// Brief    : Register map, FSM states and STATUS layout of the AHB-Lite
//            subordinate that fronts the combine datapath.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_sub_pkg;

    // Byte offsets of the 64-bit registers.
    localparam logic [5:0] c_off_input   = 6'h00;
    localparam logic [5:0] c_off_weight  = 6'h08;
    localparam logic [5:0] c_off_output  = 6'h10;
    localparam logic [5:0] c_off_control = 6'h18;
    localparam logic [5:0] c_off_status  = 6'h20;

    // Doubleword index of each register (haddr[5:3]); the byte lane bits are ignored.
    localparam logic [2:0] c_idx_input   = c_off_input[5:3];
    localparam logic [2:0] c_idx_weight  = c_off_weight[5:3];
    localparam logic [2:0] c_idx_output  = c_off_output[5:3];
    localparam logic [2:0] c_idx_control = c_off_control[5:3];
    localparam logic [2:0] c_idx_status  = c_off_status[5:3];

    // CONTROL register bits.
    localparam int unsigned c_ctrl_start = 0;
    localparam int unsigned c_ctrl_load  = 1;

    // STATUS register bits; the four error bits are contiguous and sticky.
    localparam int unsigned c_stat_ready    = 0;
    localparam int unsigned c_stat_busy     = 1;
    localparam int unsigned c_stat_err_i    = 2;
    localparam int unsigned c_stat_err_o    = 3;
    localparam int unsigned c_stat_err_w    = 4;
    localparam int unsigned c_stat_busy_err = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RD1   = 3'd3,
        ST_RD2   = 3'd4,
        ST_ERR1  = 3'd5,
        ST_ERR2  = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_subordinate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ahb_subordinate
// Brief    : AHB-Lite register slave for the combine datapath: INPUT/WEIGHT
//            payload registers, CONTROL strobes, OUTPUT read and STATUS (W1C).
// Revision : 1.0 - initial release
// ============================================================================
module ahb_subordinate
    import ahb_sub_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [5:0]  haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [63:0] hwdata,
    output logic [63:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic [63:0] input_data,
    output logic [63:0] weight_data,
    output logic        write_input,
    output logic        write_weight,
    output logic        load_weight,
    output logic        start_inference,
    output logic        output_read,
    input  logic        data_ready,
    input  logic        design_busy,
    input  logic        occupancy_err_i,
    input  logic        occupancy_err_o,
    input  logic        occupancy_err_w,
    input  logic        device_busy_err,
    input  logic [63:0] output_data
);

    state_e      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic [63:0] input_data_q, input_data_d;
    logic [63:0] weight_data_q, weight_data_d;
    logic [63:0] rdata_q, rdata_d;
    logic [3:0]  sticky_q, sticky_d;
    logic        write_input_q, write_input_d;
    logic        write_weight_q, write_weight_d;
    logic        load_weight_q, load_weight_d;
    logic        start_inference_q, start_inference_d;

    logic        w_capture;
    logic [2:0]  w_idx;
    state_e      w_decode;
    logic        w_wr_done;
    logic [3:0]  w_clr;
    logic [63:0] w_status;
    logic        w_unused;

    // Transfer size and byte-lane address bits carry no meaning for a 64-bit-only slave.
    assign w_unused = ^{hsize, htrans[0], haddr[2:0]};

    // Address-phase decode: pick the data-phase state for the transfer being offered.
    always_comb begin
        w_idx     = haddr[5:3];
        w_capture = hsel & htrans[1] & hready;
        case (w_idx)
            c_idx_input,
            c_idx_weight,
            c_idx_control: w_decode = hwrite ? ST_WDATA : ST_ERR1;
            c_idx_output:  w_decode = (!hwrite && data_ready) ? ST_RD1 : ST_ERR1;
            c_idx_status:  w_decode = hwrite ? ST_WDATA : ST_RD2;
            default:       w_decode = ST_ERR1;
        endcase
    end

    // Live STATUS word: level bits straight from the datapath, error bits from the sticky flops.
    always_comb begin
        w_status                        = '0;
        w_status[c_stat_ready]          = data_ready;
        w_status[c_stat_busy]           = design_busy;
        w_status[c_stat_err_i +: 4]     = sticky_q;
    end

    // Bus response: only payload/control writes stall on design_busy; STATUS writes never wait.
    always_comb begin
        hready      = 1'b1;
        hresp       = 1'b0;
        hrdata      = '0;
        output_read = 1'b0;
        case (state_q)
            ST_WDATA,
            ST_WAIT:  hready = !(design_busy && (addr_q != c_idx_status));
            ST_RD1: begin
                hready      = 1'b0;
                output_read = 1'b1;
            end
            ST_RD2:   hrdata = (addr_q == c_idx_status) ? w_status : rdata_q;
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2:  hresp = 1'b1;
            default: ;
        endcase
    end

    // Next state, register updates and strobes; a completing data phase may overlap a new address phase.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        input_data_d      = input_data_q;
        weight_data_d     = weight_data_q;
        rdata_d           = rdata_q;
        write_input_d     = 1'b0;
        write_weight_d    = 1'b0;
        load_weight_d     = 1'b0;
        start_inference_d = 1'b0;
        w_clr             = '0;
        w_wr_done         = ((state_q == ST_WDATA) || (state_q == ST_WAIT)) && hready;

        // Snapshot the result before output_read lets the datapath move on.
        if (state_q == ST_RD1) begin
            rdata_d = output_data;
        end

        if (w_wr_done) begin
            case (addr_q)
                c_idx_input: begin
                    input_data_d  = hwdata;
                    write_input_d = 1'b1;
                end
                c_idx_weight: begin
                    weight_data_d  = hwdata;
                    write_weight_d = 1'b1;
                end
                c_idx_control: begin
                    start_inference_d = hwdata[c_ctrl_start];
                    load_weight_d     = hwdata[c_ctrl_load];
                end
                c_idx_status: w_clr = hwdata[c_stat_err_i +: 4];
                default: ;
            endcase
        end

        // A new error pulse wins over a clear in the same cycle.
        sticky_d = (sticky_q & ~w_clr) |
                   {device_busy_err, occupancy_err_w, occupancy_err_o, occupancy_err_i};

        if (hready) begin
            state_d = w_capture ? w_decode : ST_IDLE;
            if (w_capture) begin
                addr_d = w_idx;
            end
        end else begin
            case (state_q)
                ST_WDATA: state_d = ST_WAIT;
                ST_RD1:   state_d = ST_RD2;
                ST_ERR1:  state_d = ST_ERR2;
                default:  state_d = state_q;
            endcase
        end
    end

    // State and register file; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q           <= ST_IDLE;
            addr_q            <= '0;
            input_data_q      <= '0;
            weight_data_q     <= '0;
            rdata_q           <= '0;
            sticky_q          <= '0;
            write_input_q     <= 1'b0;
            write_weight_q    <= 1'b0;
            load_weight_q     <= 1'b0;
            start_inference_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            input_data_q      <= input_data_d;
            weight_data_q     <= weight_data_d;
            rdata_q           <= rdata_d;
            sticky_q          <= sticky_d;
            write_input_q     <= write_input_d;
            write_weight_q    <= write_weight_d;
            load_weight_q     <= load_weight_d;
            start_inference_q <= start_inference_d;
        end
    end

    assign input_data      = input_data_q;
    assign weight_data     = weight_data_q;
    assign write_input     = write_input_q;
    assign write_weight    = write_weight_q;
    assign load_weight     = load_weight_q;
    assign start_inference = start_inference_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_subordinate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ahb_subordinate
// Brief    : Self-checking bench for ahb_subordinate: directed vector table,
//            multi-cycle corner sequences and randomized transfers against a
//            transaction-level register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_subordinate;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        hsel = 1'b0;
    logic [5:0]  haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = 3'b011;
    logic        hwrite = 1'b0;
    logic [63:0] hwdata = '0;
    logic [63:0] hrdata;
    logic        hready, hresp;
    logic [63:0] input_data, weight_data;
    logic        write_input, write_weight, load_weight, start_inference, output_read;
    logic        data_ready = 1'b0, design_busy = 1'b0;
    logic        occupancy_err_i = 1'b0, occupancy_err_o = 1'b0;
    logic        occupancy_err_w = 1'b0, device_busy_err = 1'b0;
    logic [63:0] output_data = '0;

    always #5 clk = ~clk;

    ahb_subordinate dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .input_data(input_data), .weight_data(weight_data),
        .write_input(write_input), .write_weight(write_weight), .load_weight(load_weight),
        .start_inference(start_inference), .output_read(output_read),
        .data_ready(data_ready), .design_busy(design_busy),
        .occupancy_err_i(occupancy_err_i), .occupancy_err_o(occupancy_err_o),
        .occupancy_err_w(occupancy_err_w), .device_busy_err(device_busy_err),
        .output_data(output_data)
    );

    int checks = 0;
    int errors = 0;

    // Strobe-high cycle counters: a strobe stuck high shows up as an extra count.
    int n_wi = 0, n_ww = 0, n_lw = 0, n_si = 0, n_or = 0, n_both = 0;
    always @(negedge clk) begin
        if (write_input)                    n_wi++;
        if (write_weight)                   n_ww++;
        if (load_weight)                    n_lw++;
        if (start_inference)                n_si++;
        if (output_read)                    n_or++;
        if (load_weight && start_inference) n_both++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] pk(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f)};
    endfunction

    function automatic logic [47:0] strobe_snap();
        return pk(n_wi, n_ww, n_lw, n_si, n_or, n_both);
    endfunction

    // One non-pipelined transfer; returns wait cycles, ERROR seen anywhere, ERROR at completion, read data.
    task automatic do_xfer(input logic [5:0] addr, input logic wr, input logic [63:0] wdata,
                           input int nbusy, output int waits, output logic resp_any,
                           output logic resp_last, output logic [63:0] rdata);
        int j;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = 3'b011; design_busy = 1'b0;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = wdata;
        design_busy = (nbusy > 0);
        j = 0; waits = 0; resp_any = 1'b0;
        #1;
        while (!hready && waits < 50) begin
            resp_any = resp_any | hresp;
            waits++; j++;
            @(negedge clk);
            design_busy = (j < nbusy);
            #1;
        end
        if (!hready) chk("xfer_timeout", {63'b0, hready}, 64'd1);
        resp_any  = resp_any | hresp;
        resp_last = hresp;
        rdata     = hrdata;
        @(negedge clk);
        design_busy = 1'b0; hwdata = '0;
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic        wr;
        logic [63:0] wdata;
        int          nbusy;
        logic        dready;
        logic [63:0] odata;
        logic        err;
        int          waits;
        logic [63:0] rdata;
        logic [47:0] strobes;  // {wi, ww, lw, si, or, both}
    } vec_t;

    vec_t        vecs[14];
    int          w;
    logic        ra, rl;
    logic [63:0] rd;
    logic [47:0] s0, s1;

    // Transaction-level model state for the random phase.
    logic [63:0] m_input, m_weight;
    logic [3:0]  m_sticky;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hready", {63'b0, hready}, 64'd1);
        chk("rst_hresp", {63'b0, hresp}, 64'd0);
        chk("rst_hrdata", hrdata, 64'd0);
        chk("rst_data", input_data | weight_data, 64'd0);
        chk("rst_strobes", {59'b0, write_input, write_weight, load_weight, start_inference, output_read}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // ---------------- directed vector table ----------------
        vecs[0]  = '{6'h00, 1'b1, 64'h0123456789ABCDEF, 0, 1'b0, 64'h0, 1'b0, 0, 64'h0, pk(1,0,0,0,0,0)};
        vecs[1]  = '{6'h08, 1'b1, 64'hCAFEF00D12345678, 2, 1'b0, 64'h0, 1'b0, 2, 64'h0, pk(0,1,0,0,0,0)};
        vecs[2]  = '{6'h18, 1'b1, 64'h3,                5, 1'b0, 64'h0, 1'b0, 5, 64'h0, pk(0,0,1,1,0,1)};
        vecs[3]  = '{6'h10, 1'b0, 64'h0,                0, 1'b1, 64'hDEADBEEF, 1'b0, 1, 64'hDEADBEEF, pk(0,0,0,0,1,0)};
        vecs[4]  = '{6'h10, 1'b0, 64'h0,                0, 1'b0, 64'hDEADBEEF, 1'b1, 1, 64'h0, pk(0,0,0,0,0,0)};
        vecs[5]  = '{6'h10, 1'b1, 64'h5,                0, 1'b1, 64'h0, 1'b1, 1, 64'h0, pk(0,0,0,0,0,0)};
        vecs[6]  = '{6'h00, 1'b0, 64'h0,                0, 1'b1, 64'h0, 1'b1, 1, 64'h0, pk(0,0,0,0,0,0)};
        vecs[7]  = '{6'h18, 1'b0, 64'h0,                0, 1'b1, 64'h0, 1'b1, 1, 64'h0, pk(0,0,0,0,0,0)};
        vecs[8]  = '{6'h28, 1'b0, 64'h0,                0, 1'b1, 64'h0, 1'b1, 1, 64'h0, pk(0,0,0,0,0,0)};
        vecs[9]  = '{6'h38, 1'b1, 64'h1,                0, 1'b1, 64'h0, 1'b1, 1, 64'h0, pk(0,0,0,0,0,0)};
        vecs[10] = '{6'h20, 1'b0, 64'h0,                1, 1'b1, 64'h0, 1'b0, 0, 64'h3, pk(0,0,0,0,0,0)};
        vecs[11] = '{6'h18, 1'b1, 64'h1,                0, 1'b0, 64'h0, 1'b0, 0, 64'h0, pk(0,0,0,1,0,0)};
        vecs[12] = '{6'h1C, 1'b1, 64'h2,                1, 1'b0, 64'h0, 1'b0, 1, 64'h0, pk(0,0,1,0,0,0)};
        vecs[13] = '{6'h22, 1'b1, 64'h0,                3, 1'b0, 64'h0, 1'b0, 0, 64'h0, pk(0,0,0,0,0,0)};

        for (int i = 0; i < 14; i++) begin
            data_ready  = vecs[i].dready;
            output_data = vecs[i].odata;
            s0 = strobe_snap();
            do_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].nbusy, w, ra, rl, rd);
            @(negedge clk); #1;
            s1 = strobe_snap();
            chk($sformatf("vec%0d_waits", i), 64'(w), 64'(vecs[i].waits));
            chk($sformatf("vec%0d_resp", i), {62'b0, ra, rl}, {62'b0, vecs[i].err, vecs[i].err});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d_strobes", i), 64'(s1 - s0), 64'(vecs[i].strobes));
        end
        chk("tbl_input_data", input_data, 64'h0123456789ABCDEF);
        chk("tbl_weight_data", weight_data, 64'hCAFEF00D12345678);
        chk("tbl_idle_hrdata", hrdata, 64'd0);

        // ---------------- sticky STATUS set / W1C / set-wins ----------------
        data_ready = 1'b0;
        @(negedge clk); occupancy_err_w = 1'b1;
        @(negedge clk); occupancy_err_w = 1'b0;
        do_xfer(6'h20, 1'b0, 64'h0, 0, w, ra, rl, rd);
        chk("sticky_set", rd, 64'h10);
        do_xfer(6'h20, 1'b1, 64'h10, 0, w, ra, rl, rd);
        do_xfer(6'h20, 1'b0, 64'h0, 0, w, ra, rl, rd);
        chk("sticky_cleared", rd, 64'h0);
        occupancy_err_w = 1'b1;
        do_xfer(6'h20, 1'b1, 64'h10, 0, w, ra, rl, rd);
        occupancy_err_w = 1'b0;
        do_xfer(6'h20, 1'b0, 64'h0, 0, w, ra, rl, rd);
        chk("sticky_set_wins", rd, 64'h10);
        do_xfer(6'h20, 1'b1, 64'h3C, 0, w, ra, rl, rd);

        // ---------------- back-to-back: 3 transfers in 4 cycles ----------------
        data_ready = 1'b1;
        s0 = strobe_snap();
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 6'h00; hwrite = 1'b1; #1;
        chk("b2b_c1_hready", {63'b0, hready}, 64'd1);
        @(negedge clk);
        haddr = 6'h08; hwdata = 64'hA1A1A1A1A1A1A1A1; #1;
        chk("b2b_c2_hready", {63'b0, hready}, 64'd1);
        @(negedge clk);
        haddr = 6'h20; hwrite = 1'b0; hwdata = 64'hB2B2B2B2B2B2B2B2; #1;
        chk("b2b_c3_hready", {63'b0, hready}, 64'd1);
        chk("b2b_c3_write_input", {63'b0, write_input}, 64'd1);
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = '0; #1;
        chk("b2b_c4_hready", {63'b0, hready}, 64'd1);
        chk("b2b_c4_status", hrdata, 64'h1);
        chk("b2b_c4_write_weight", {63'b0, write_weight}, 64'd1);
        @(negedge clk); #1;
        s1 = strobe_snap();
        chk("b2b_data", {input_data[31:0], weight_data[31:0]}, 64'hA1A1A1A1_B2B2B2B2);
        chk("b2b_strobes", 64'(s1 - s0), 64'(pk(1,1,0,0,0,0)));

        // ---------------- reset during a WAIT stall ----------------
        s0 = strobe_snap();
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 6'h00; hwrite = 1'b1; design_busy = 1'b1;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 64'h5555AAAA5555AAAA; #1;
        chk("rstw_stall1", {63'b0, hready}, 64'd0);
        @(negedge clk); #1;
        chk("rstw_stall2", {63'b0, hready}, 64'd0);
        n_rst = 1'b0; #1;
        chk("rstw_bus", {hrdata[61:0], hready, hresp}, 64'h2);
        chk("rstw_data", input_data | weight_data, 64'd0);
        chk("rstw_strobes", {59'b0, write_input, write_weight, load_weight, start_inference, output_read}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1; design_busy = 1'b0; hwdata = '0;
        repeat (3) @(negedge clk);
        #1;
        s1 = strobe_snap();
        chk("rstw_no_strobe", 64'(s1 - s0), 64'd0);
        chk("rstw_input_hold", input_data, 64'd0);

        // ---------------- randomized transfers vs register model ----------------
        m_input = '0; m_weight = '0; m_sticky = '0;
        for (int t = 0; t < 60; t++) begin
            logic [3:0]  ev;
            logic [2:0]  ridx;
            logic        rwr;
            logic [63:0] rwd;
            int          nb;
            logic        e_err;
            int          e_waits;
            logic [63:0] e_rdata;
            int          e_wi, e_ww, e_lw, e_si, e_or, e_both;

            ev = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            @(negedge clk);
            {device_busy_err, occupancy_err_w, occupancy_err_o, occupancy_err_i} = ev;
            @(negedge clk);
            {device_busy_err, occupancy_err_w, occupancy_err_o, occupancy_err_i} = 4'h0;
            m_sticky = m_sticky | ev;

            ridx = 3'($urandom_range(0, 7));
            rwr  = 1'($urandom_range(0, 1));
            rwd  = {$urandom, $urandom};
            nb   = $urandom_range(0, 3);
            data_ready  = 1'($urandom_range(0, 1));
            output_data = {$urandom, $urandom};

            e_err = 1'b1; e_waits = 1; e_rdata = '0;
            e_wi = 0; e_ww = 0; e_lw = 0; e_si = 0; e_or = 0; e_both = 0;
            case (ridx)
                3'd0: if (rwr) begin e_err = 1'b0; e_waits = nb; m_input = rwd; e_wi = 1; end
                3'd1: if (rwr) begin e_err = 1'b0; e_waits = nb; m_weight = rwd; e_ww = 1; end
                3'd2: if (!rwr && data_ready) begin e_err = 1'b0; e_rdata = output_data; e_or = 1; end
                3'd3: if (rwr) begin
                    e_err = 1'b0; e_waits = nb;
                    e_lw = int'(rwd[1]); e_si = int'(rwd[0]); e_both = int'(rwd[1] & rwd[0]);
                end
                3'd4: begin
                    e_err = 1'b0; e_waits = 0;
                    if (!rwr) e_rdata = {58'b0, m_sticky, (nb > 0), data_ready};
                end
                default: ;
            endcase

            s0 = strobe_snap();
            do_xfer({ridx, 3'($urandom_range(0, 7))}, rwr, rwd, nb, w, ra, rl, rd);
            if (ridx == 3'd4 && rwr) m_sticky = m_sticky & ~rwd[5:2];
            @(negedge clk); #1;
            s1 = strobe_snap();
            chk($sformatf("rnd%0d_waits", t), 64'(w), 64'(e_waits));
            chk($sformatf("rnd%0d_resp", t), {62'b0, ra, rl}, {62'b0, e_err, e_err});
            chk($sformatf("rnd%0d_rdata", t), rd, e_rdata);
            chk($sformatf("rnd%0d_strobes", t), 64'(s1 - s0), 64'(pk(e_wi, e_ww, e_lw, e_si, e_or, e_both)));
            chk($sformatf("rnd%0d_input", t), input_data, m_input);
            chk($sformatf("rnd%0d_weight", t), weight_data, m_weight);
            chk($sformatf("rnd%0d_idle", t), {hrdata[61:0], hready, hresp}, 64'h2);
        end

        // Final sticky readback ties the model's accumulated error bits to the DUT.
        data_ready = 1'b0;
        do_xfer(6'h20, 1'b0, 64'h0, 0, w, ra, rl, rd);
        chk("final_status", rd, {58'b0, m_sticky, 2'b00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a wedged DUT still produces a summary.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
